// File: rtl/text_pkg.sv
// Shared types and helpers for the text-mode pixel pipeline.
// Attribute byte layout, pipeline control word and RGB expansion.
package text_pkg;

    localparam int LATENCY     = 4;

    localparam int ATTR_FG_LSB = 0;
    localparam int ATTR_BG_LSB = 3;
    localparam int ATTR_UL     = 6;
    localparam int ATTR_BLINK  = 7;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Control word carried alongside each pixel through the pipeline.
    typedef struct packed {
        logic       de;
        logic       hsync;
        logic       vsync;
        logic       oob;
        logic       cur_hit;
        logic [3:0] x;
        logic [4:0] y;
    } pix_ctl_t;

    // 3-bit colour: bit 2 = blue, bit 1 = red, bit 0 = green.
    function automatic rgb565_t expand_rgb(input logic [2:0] rgb);
        rgb565_t c;
        c.r = {5{rgb[1]}};
        c.g = {6{rgb[0]}};
        c.b = {5{rgb[2]}};
        return c;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Frame-based blink phase generator: counts vsync rising edges and
// toggles the phase every BLINK_FRAMES frames.
module blink_timer
#(
    parameter int BLINK_FRAMES = 30
)
(
    input  logic clk,
    input  logic reset,
    input  logic i_vsync,
    output logic o_phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic             r_vs_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_vs_rise;

    assign w_vs_rise = i_vsync & ~r_vs_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values; blocking here would chain updates in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_d  <= 1'b0;
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else begin
            r_vs_d <= i_vsync;
            if (w_vs_rise) begin
                if (32'(r_cnt) == BLINK_FRAMES - 1) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/text_renderer.sv
// Text-mode pixel pipeline: screen RAM -> glyph ROM -> attributes/cursor
// -> LCD, with sync signals delayed to stay aligned (latency 4).
module text_renderer
    import text_pkg::*;
#(
    parameter int COLS         = 80,
    parameter int ROWS         = 24,
    parameter int GLYPH_W      = 10,
    parameter int GLYPH_H      = 20,
    parameter int CURSOR_TOP   = 18,
    parameter int BLINK_FRAMES = 30,
    parameter int ADDR_W       = $clog2(COLS * ROWS)
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_de,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic [6:0]         in_col,
    input  logic [4:0]         in_row,
    input  logic [3:0]         in_x,
    input  logic [4:0]         in_y,
    input  logic               cursor_en,
    input  logic [6:0]         cursor_col,
    input  logic [4:0]         cursor_row,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [15:0]        ram_data,
    output logic [7:0]         rom_char,
    output logic [4:0]         rom_row,
    input  logic [GLYPH_W-1:0] rom_q,
    output logic               lcd_de,
    output logic               lcd_hsync,
    output logic               lcd_vsync,
    output logic [4:0]         lcd_r,
    output logic [5:0]         lcd_g,
    output logic [4:0]         lcd_b
);

    logic              w_phase;
    logic              w_oob;
    logic              w_cur_hit;
    logic [ADDR_W-1:0] w_lin_addr;
    pix_ctl_t          w_s1_next;

    pix_ctl_t          r_s1;
    pix_ctl_t          r_s2;
    pix_ctl_t          r_s3;
    logic [7:0]        r_s3_attr;
    logic [ADDR_W-1:0] r_ram_addr;

    logic [GLYPH_W-1:0] w_row_sh;
    logic               w_fg_on;
    logic [2:0]         w_sel;
    rgb565_t            w_rgb;

    logic               r_lcd_de;
    logic               r_lcd_hsync;
    logic               r_lcd_vsync;
    rgb565_t            r_lcd_rgb;

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk     (clk),
        .reset   (reset),
        .i_vsync (in_vsync),
        .o_phase (w_phase)
    );

    // Stage 1: address generation and per-pixel flags.
    assign w_oob      = (32'(in_col) >= COLS) || (32'(in_row) >= ROWS);
    assign w_cur_hit  = cursor_en && (in_col == cursor_col) &&
                        (in_row == cursor_row) && (32'(in_y) >= CURSOR_TOP);
    assign w_lin_addr = ADDR_W'(32'(in_row) * COLS + 32'(in_col));

    always_comb begin
        w_s1_next         = '0;
        w_s1_next.de      = in_de;
        w_s1_next.hsync   = in_hsync;
        w_s1_next.vsync   = in_vsync;
        w_s1_next.oob     = w_oob;
        w_s1_next.cur_hit = w_cur_hit;
        w_s1_next.x       = in_x;
        w_s1_next.y       = in_y;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_s3_attr  <= '0;
            r_ram_addr <= '0;
        end else begin
            r_s1       <= w_s1_next;
            r_ram_addr <= w_oob ? '0 : w_lin_addr;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_s3_attr  <= ram_data[15:8];
        end
    end

    assign ram_addr = r_ram_addr;

    // Stage 2: RAM word is valid now; drive the ROM address directly from it.
    assign rom_char = ram_data[7:0];
    assign rom_row  = r_s2.y;

    // Stage 3: pick the pixel bit (MSB = leftmost), apply attributes.
    assign w_row_sh = rom_q << r_s3.x;

    // NOTE: every always_comb output is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_fg_on = w_row_sh[GLYPH_W-1];
        if (r_s3_attr[ATTR_UL] && (32'(r_s3.y) == GLYPH_H - 1))
            w_fg_on = 1'b1;
        if (r_s3_attr[ATTR_BLINK] && !w_phase)
            w_fg_on = 1'b0;
        if (r_s3.cur_hit && w_phase)
            w_fg_on = ~w_fg_on;

        w_sel = w_fg_on ? r_s3_attr[ATTR_FG_LSB +: 3] : r_s3_attr[ATTR_BG_LSB +: 3];
        w_rgb = expand_rgb(w_sel);
        if (r_s3.oob || !r_s3.de)
            w_rgb = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lcd_de    <= 1'b0;
            r_lcd_hsync <= 1'b0;
            r_lcd_vsync <= 1'b0;
            r_lcd_rgb   <= '0;
        end else begin
            r_lcd_de    <= r_s3.de;
            r_lcd_hsync <= r_s3.hsync;
            r_lcd_vsync <= r_s3.vsync;
            r_lcd_rgb   <= w_rgb;
        end
    end

    assign lcd_de    = r_lcd_de;
    assign lcd_hsync = r_lcd_hsync;
    assign lcd_vsync = r_lcd_vsync;
    assign lcd_r     = r_lcd_rgb.r;
    assign lcd_g     = r_lcd_rgb.g;
    assign lcd_b     = r_lcd_rgb.b;

endmodule
